// File: rtl/step_drv_arbiter_pkg.sv
// Shared definitions for the stepper-driver arbiter.
//   state_e       : FSM state encoding (IDLE, SETUP, HIGH, LOW)
//   GNT_*         : grant output encoding
//   DEF_*         : default timing parameters in clk cycles at 50 MHz
//   clamp_period  : max(period, min_period)
package step_drv_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_TR   = 2'b01;
  localparam logic [1:0] GNT_MAN  = 2'b10;

  localparam int DEF_WIDTH_WORK = 16;
  localparam int DEF_PULSE_W    = 50;
  localparam int DEF_DIR_SETUP  = 25;
  localparam int DEF_MIN_PERIOD = 100;

  function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                               input logic [31:0] min_period);
    return (period >= min_period) ? period : min_period;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter used for the SETUP, HIGH and LOW phase lengths.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase length in cycles (>= 1)
//   done       : high on the last cycle of the loaded interval
module step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A value of N loaded at the phase entry edge gives exactly N cycles in
  // that phase; 0 is treated as expired so the FSM can never stall.
  assign done = (cnt_q <= W'(1));

endmodule

// File: rtl/step_drv_arbiter.sv
// Arbitrates a stepper driver between a tracking requester (level, free
// running) and a manual requester (counted move) and generates the
// step/dir waveform with direction setup time, pulse width and minimum
// step period.
//   clk, rst                  : clock, asynchronous active-high reset
//   tr_req/tr_dir/tr_period   : tracking request, direction, period (0 = hold)
//   man_start/dir/period/steps: manual move request, sampled on man_start
//   drv_step/drv_dir/drv_enable: motor driver outputs
//   grant                     : current owner (00 none, 01 tracking, 10 manual)
//   man_busy/man_done         : manual move status
module step_drv_arbiter
  import step_drv_arbiter_pkg::*;
#(
  parameter int WIDTH_WORK = DEF_WIDTH_WORK,
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int DIR_SETUP  = DEF_DIR_SETUP,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tr_req,
  input  logic                  tr_dir,
  input  logic [WIDTH_WORK-1:0] tr_period,
  input  logic                  man_start,
  input  logic                  man_dir,
  input  logic [WIDTH_WORK-1:0] man_period,
  input  logic [WIDTH_WORK-1:0] man_steps,
  output logic                  drv_step,
  output logic                  drv_dir,
  output logic                  drv_enable,
  output logic [1:0]            grant,
  output logic                  man_busy,
  output logic                  man_done
);

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  drv_step_q, drv_step_d;
  logic                  drv_dir_q, drv_dir_d;
  logic                  drv_enable_q, drv_enable_d;
  logic                  man_busy_q, man_busy_d;
  logic                  man_done_q, man_done_d;
  logic                  m_dir_q, m_dir_d;
  logic [WIDTH_WORK-1:0] m_period_q, m_period_d;
  logic [WIDTH_WORK-1:0] rem_q, rem_d;
  logic [WIDTH_WORK-1:0] eff_q, eff_d;

  logic                  tmr_load;
  logic [WIDTH_WORK-1:0] tmr_val;
  logic                  tmr_done;

  logic                  man_pend;
  logic [1:0]            grant_sel;
  logic                  own_dir;
  logic [WIDTH_WORK-1:0] own_period;
  logic                  start_pulse;

  step_timer #(.W(WIDTH_WORK)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Owner selection: only re-evaluated in IDLE, held otherwise. A manual
  // move with steps remaining beats tracking.
  always_comb begin
    man_pend  = man_busy_q && (rem_q != '0);
    grant_sel = grant_q;
    if (state_q == ST_IDLE) begin
      if (man_pend)    grant_sel = GNT_MAN;
      else if (tr_req) grant_sel = GNT_TR;
      else             grant_sel = GNT_NONE;
    end
    own_dir    = (grant_sel == GNT_MAN) ? m_dir_q    : tr_dir;
    own_period = (grant_sel == GNT_MAN) ? m_period_q : tr_period;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_sel;
    drv_dir_d   = drv_dir_q;
    man_busy_d  = man_busy_q;
    man_done_d  = 1'b0;
    m_dir_d     = m_dir_q;
    m_period_d  = m_period_q;
    rem_d       = rem_q;
    eff_d       = eff_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    start_pulse = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_sel == GNT_MAN || (grant_sel == GNT_TR && tr_period != '0)) begin
          if (own_dir != drv_dir_q) begin
            drv_dir_d = own_dir;
            state_d   = ST_SETUP;
            tmr_load  = 1'b1;
            tmr_val   = WIDTH_WORK'(DIR_SETUP);
          end else begin
            start_pulse = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_done) start_pulse = 1'b1;
      end
      ST_HIGH: begin
        if (tmr_done) begin
          // The IDLE cycle before the next rising edge is part of the period.
          state_d  = ST_LOW;
          tmr_load = 1'b1;
          tmr_val  = eff_q - WIDTH_WORK'(PULSE_W) - WIDTH_WORK'(1);
        end
      end
      ST_LOW: begin
        if (grant_q == GNT_TR && !tr_req) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
          if (grant_q == GNT_MAN && rem_q == '0) begin
            man_done_d = 1'b1;
            man_busy_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_pulse) begin
      state_d  = ST_HIGH;
      tmr_load = 1'b1;
      tmr_val  = WIDTH_WORK'(PULSE_W);
      eff_d    = WIDTH_WORK'(clamp_period(32'(own_period), 32'(MIN_PERIOD)));
      if (grant_sel == GNT_MAN) rem_d = rem_q - 1'b1;
    end

    // Zero-step move: never takes ownership, completes on the next cycle.
    if (man_busy_q && rem_q == '0 && grant_q != GNT_MAN) begin
      man_done_d = 1'b1;
      man_busy_d = 1'b0;
    end

    if (man_start && !man_busy_q) begin
      man_busy_d = 1'b1;
      m_dir_d    = man_dir;
      m_period_d = man_period;
      rem_d      = man_steps;
    end

    drv_step_d   = (state_d == ST_HIGH);
    drv_enable_d = (grant_d != GNT_NONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_NONE;
      drv_step_q   <= 1'b0;
      drv_dir_q    <= 1'b0;
      drv_enable_q <= 1'b0;
      man_busy_q   <= 1'b0;
      man_done_q   <= 1'b0;
      m_dir_q      <= 1'b0;
      m_period_q   <= '0;
      rem_q        <= '0;
      eff_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      drv_step_q   <= drv_step_d;
      drv_dir_q    <= drv_dir_d;
      drv_enable_q <= drv_enable_d;
      man_busy_q   <= man_busy_d;
      man_done_q   <= man_done_d;
      m_dir_q      <= m_dir_d;
      m_period_q   <= m_period_d;
      rem_q        <= rem_d;
      eff_q        <= eff_d;
    end
  end

  assign drv_step   = drv_step_q;
  assign drv_dir    = drv_dir_q;
  assign drv_enable = drv_enable_q;
  assign grant      = grant_q;
  assign man_busy   = man_busy_q;
  assign man_done   = man_done_q;

endmodule

// File: doc/step_drv_arbiter.md
STEP_DRV_ARBITER -- requirements
Module: step_drv_arbiter

Interface
REQ-001 Parameter WIDTH_WORK, default 16: width of period and step-count fields.
REQ-002 Parameter PULSE_W, default 50: drv_step high time in clk cycles (1 us at 50 MHz).
REQ-003 Parameter DIR_SETUP, default 25: cycles drv_dir is held stable before a rising drv_step.
REQ-004 Parameter MIN_PERIOD, default 100: minimum rising-to-rising step interval in cycles; MIN_PERIOD > PULSE_W.
REQ-005 clk  in  1  50 MHz system clock.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 tr_req  in  1  tracking requester active (level).
REQ-008 tr_dir  in  1  tracking direction.
REQ-009 tr_period  in  WIDTH_WORK  tracking step period in cycles; 0 = no stepping.
REQ-010 man_start  in  1  one-cycle pulse starting a manual move.
REQ-011 man_dir  in  1  manual direction, sampled with man_start.
REQ-012 man_period  in  WIDTH_WORK  manual step period, sampled with man_start.
REQ-013 man_steps  in  WIDTH_WORK  manual step count, sampled with man_start.
REQ-014 drv_step  out  1  step pulse to motor driver.
REQ-015 drv_dir  out  1  direction to motor driver.
REQ-016 drv_enable  out  1  driver enable; high while any owner is granted.
REQ-017 grant  out  2  owner: 00 none, 01 tracking, 10 manual.
REQ-018 man_busy  out  1  manual move in progress.
REQ-019 man_done  out  1  one-cycle pulse at manual move completion.

Function
REQ-020 FSM states: IDLE, SETUP, HIGH, LOW; all outputs registered.
REQ-021 Arbitration only in IDLE: pending manual move wins over tr_req; grant changes only in IDLE.
REQ-022 man_start while man_busy is ignored; accepted man_start sets man_busy next cycle and latches dir/period/steps.
REQ-023 man_steps=0: man_done pulses one cycle after acceptance, no step issued, man_busy clears with it.
REQ-024 Effective period = max(period, MIN_PERIOD), latched on entry to HIGH; period 0 for tracking keeps FSM in IDLE with grant=01, no pulses.
REQ-025 If owner direction differs from drv_dir: drv_dir updates on leaving IDLE, then SETUP for exactly DIR_SETUP cycles, then HIGH; otherwise IDLE->HIGH directly.
REQ-026 HIGH: drv_step=1 for exactly PULSE_W cycles; LOW: drv_step=0 until effective period elapsed from rising edge, then IDLE (re-arbitrate).
REQ-027 Manual: remaining count decrements at each rising drv_step; man_done pulses and man_busy clears on the cycle LOW completes after last step.
REQ-028 tr_req falling during HIGH: pulse completes full width; LOW is cut short and FSM returns to IDLE.
REQ-029 drv_enable = (grant != 00); grant returns to 00 in IDLE when no requester active.
REQ-030 Counters saturate-free: period counter WIDTH_WORK bits, compares with >=; no wrap.

Reset
REQ-031 rst forces state IDLE, drv_step=0, drv_dir=0, drv_enable=0, grant=00, man_busy=0, man_done=0, counters 0, any manual move aborted without man_done.
REQ-032 rst asserted mid-pulse drops drv_step immediately (asynchronous).

Structure
REQ-033 Shared package holds state encoding, grant encoding constants, and default PULSE_W/DIR_SETUP/MIN_PERIOD.
REQ-034 One sub-module step_timer (loadable down-counter with done flag) is used for SETUP, HIGH and LOW timing.

Verification
REQ-035 tr_req=1, tr_dir=0, tr_period=200 -> rising drv_step every 200 cycles, each high 50 cycles, grant=01.
REQ-036 man_start with steps=3, period=40 -> 3 pulses 100 cycles apart (MIN_PERIOD clamp), then man_done one cycle, man_busy=0.
REQ-037 tr_req active while man_start arrives mid-period -> current tracking period completes, grant=10 next IDLE, manual steps run, then grant=01.
REQ-038 Direction flip 0->1 -> drv_dir changes, exactly 25 cycles before next rising drv_step.
REQ-039 man_steps=0 -> man_done one cycle after acceptance, no drv_step; man_start during busy -> ignored, count unchanged.
REQ-040 rst during HIGH -> drv_step low same cycle, all outputs at reset values, no man_done.
